// File: rtl/piso_tx_4bit.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
// load handshake and shifts it out one bit per enabled clock, with a done pulse.
module piso_tx_4bit #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ce,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] d,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned          CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]      LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // done_d defaults low outside the ce gate so the pulse self-clears even when frozen.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (ce) begin
      unique case (state_q)
        StIdle: begin
          if (load_valid) begin
            shreg_d = d;
            count_d = '0;
            state_d = StShift;
          end
        end
        StShift: begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          if (count_q == LastCnt) begin
            state_d = StIdle;
            count_d = '0;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    sout_valid = 1'b0;
    sout       = 1'b0;
    if (state_q == StShift) begin
      busy       = 1'b1;
      sout_valid = 1'b1;
      sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end else begin
      load_ready = 1'b1;
    end
    done = done_q;
  end

endmodule
